dlsc_apb_regbank: RTL and testbench



---
 rtl/dlsc_apb_pkg.sv | 24 ++
 rtl/dlsc_apb_regbank_reg.sv | 49 ++++
 rtl/dlsc_apb_regbank.sv | 100 ++++++++++
 tb/tb_dlsc_apb_regbank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlsc_apb_pkg.sv
// Shared APB definitions: phase encodings for benches and strobe-width helpers.
package dlsc_apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_phase_t;

    // Number of byte-offset address bits below the register index.
    function automatic int strb_log2(input int strb);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < strb) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dlsc_apb_regbank_reg.sv
// One control register: byte-strobed write, parameterised reset value and a
// write pulse that lines up with the updated value.
module dlsc_apb_regbank_reg
    import dlsc_apb_pkg::*;
#(
    parameter int              DATA      = 32,
    parameter int              STRB      = DATA / 8,
    parameter logic [DATA-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [DATA-1:0] wdata,
    input  logic [STRB-1:0] strb,
    output logic [DATA-1:0] value,
    output logic            wr_pulse
);

    logic [DATA-1:0] value_d, value_q;
    logic            wr_d, wr_q;

    // Next value: only strobed bytes change; the pulse fires even with no strobes.
    always_comb begin
        value_d = value_q;
        for (int b = 0; b < STRB; b++) begin
            if (we && strb[b]) begin
                value_d[b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                value_d[b*8 +: 8] = value_q[b*8 +: 8];
            end
        end
        wr_d = we;
    end

    // Register state and pulse flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= RESET_VAL;
            wr_q    <= 1'b0;
        end else begin
            value_q <= value_d;
            wr_q    <= wr_d;
        end
    end

    assign value    = value_q;
    assign wr_pulse = wr_q;

endmodule

// File: rtl/dlsc_apb_regbank.sv
// APB slave register bank: REGS word registers, fixed wait states, slverr on
// bad addresses, RO slots returning live status from csr_in.
module dlsc_apb_regbank
    import dlsc_apb_pkg::*;
#(
    parameter int                   ADDR    = 32,
    parameter int                   DATA    = 32,
    parameter int                   STRB    = DATA / 8,
    parameter int                   REGS    = 8,
    parameter int                   WAIT    = 0,
    parameter logic [REGS-1:0]      RO_MASK = '0,
    parameter logic [REGS*DATA-1:0] RESET   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR-1:0]      apb_addr,
    input  logic                 apb_sel,
    input  logic                 apb_enable,
    input  logic                 apb_write,
    input  logic [DATA-1:0]      apb_wdata,
    input  logic [STRB-1:0]      apb_strb,
    output logic                 apb_ready,
    output logic [DATA-1:0]      apb_rdata,
    output logic                 apb_slverr,
    output logic [REGS*DATA-1:0] csr_out,
    input  logic [REGS*DATA-1:0] csr_in,
    output logic [REGS-1:0]      csr_wr
);

    localparam int              LB       = strb_log2(STRB);
    localparam int              IDXW     = (REGS > 1) ? $clog2(REGS) : 1;
    localparam logic [ADDR-1:0] LOW_MASK = ADDR'((64'd1 << LB) - 64'd1);

    logic            access_s, ready_s, err_s, oob_s, ro_s, commit_s;
    logic [IDXW-1:0] idx_s;
    logic [3:0]      cnt_d, cnt_q;
    logic [DATA-1:0] rd_val_s;
    logic [DATA-1:0] reg_val_s [REGS];

    // Address decode: index, range/alignment/upper-bit error, RO lookup.
    always_comb begin
        idx_s    = IDXW'(apb_addr >> LB);
        oob_s    = ({1'b0, idx_s} >= (IDXW+1)'(REGS));
        err_s    = oob_s | ((apb_addr & LOW_MASK) != '0) | ((apb_addr >> (LB + IDXW)) != '0);
        ro_s     = 1'b0;
        rd_val_s = '0;
        if (!oob_s) begin
            ro_s     = RO_MASK[idx_s];
            rd_val_s = ro_s ? csr_in[idx_s*DATA +: DATA] : reg_val_s[idx_s];
        end else begin
            ro_s     = 1'b0;
            rd_val_s = '0;
        end
    end

    // Handshake: ready is combinational from the registered wait count so
    // WAIT=0 completes in the first ACCESS cycle.
    always_comb begin
        access_s   = apb_sel & apb_enable;
        ready_s    = access_s && (cnt_q == 4'(WAIT));
        cnt_d      = (!access_s || ready_s) ? 4'd0 : cnt_q + 4'd1;
        commit_s   = ready_s & apb_write & ~err_s & ~ro_s;
        apb_ready  = ready_s;
        apb_slverr = ready_s & err_s;
        apb_rdata  = (ready_s && !apb_write && !err_s) ? rd_val_s : '0;
    end

    // Wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_val_s[i]            = '0;
            assign csr_wr[i]               = 1'b0;
            assign csr_out[i*DATA +: DATA] = '0;
        end else begin : g_rw
            dlsc_apb_regbank_reg #(
                .DATA      (DATA),
                .STRB      (STRB),
                .RESET_VAL (RESET[i*DATA +: DATA])
            ) u_reg (
                .clk      (clk),
                .rst      (rst),
                .we       (commit_s && (idx_s == IDXW'(i))),
                .wdata    (apb_wdata),
                .strb     (apb_strb),
                .value    (reg_val_s[i]),
                .wr_pulse (csr_wr[i])
            );
            assign csr_out[i*DATA +: DATA] = reg_val_s[i];
        end
    end

endmodule

// File: tb/tb_dlsc_apb_regbank.sv
// Bench for dlsc_apb_regbank: a WAIT=0 bank with an RO slot and a WAIT=3 bank
// share one APB bus, each with its own select.
module tb_dlsc_apb_regbank;

    localparam int REGS = 8;
    localparam int DATA = 32;
    localparam logic [REGS*DATA-1:0] RST_VEC = {224'h0, 32'h12345678};

    logic        clk = 1'b0;
    logic        rst;
    logic        sel0, sel3, enable, write;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic        ready0, slverr0, ready3, slverr3;
    logic [31:0] rdata0, rdata3;
    logic [REGS*DATA-1:0] csr_out0, csr_out3, csr_in;
    logic [REGS-1:0]      csr_wr0, csr_wr3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dlsc_apb_regbank #(
        .ADDR(32), .DATA(DATA), .REGS(REGS), .WAIT(0),
        .RO_MASK(8'b0000_0100), .RESET(RST_VEC)
    ) u_dut0 (
        .clk(clk), .rst(rst), .apb_addr(addr), .apb_sel(sel0), .apb_enable(enable),
        .apb_write(write), .apb_wdata(wdata), .apb_strb(strb), .apb_ready(ready0),
        .apb_rdata(rdata0), .apb_slverr(slverr0), .csr_out(csr_out0), .csr_in(csr_in),
        .csr_wr(csr_wr0)
    );

    dlsc_apb_regbank #(
        .ADDR(32), .DATA(DATA), .REGS(REGS), .WAIT(3),
        .RO_MASK(8'b0000_0000), .RESET(RST_VEC)
    ) u_dut3 (
        .clk(clk), .rst(rst), .apb_addr(addr), .apb_sel(sel3), .apb_enable(enable),
        .apb_write(write), .apb_wdata(wdata), .apb_strb(strb), .apb_ready(ready3),
        .apb_rdata(rdata3), .apb_slverr(slverr3), .csr_out(csr_out3), .csr_in(csr_in),
        .csr_wr(csr_wr3)
    );

    typedef struct {
        string       name;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_cyc;
        logic [7:0]  exp_wr;
        int          chk_idx;
        logic [31:0] exp_reg;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer starting at posedge+1; returns at posedge+1 after the ready edge.
    task automatic xfer(input bit which, input logic [31:0] a, input bit w,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output bit er, output int cyc);
        bit done;
        done = 1'b0;
        rd = '0;
        er = 1'b0;
        addr = a; write = w; wdata = d; strb = s;
        enable = 1'b0; sel0 = ~which; sel3 = which;
        @(posedge clk); #1;
        enable = 1'b1;
        cyc = 2;
        while (!done) begin
            @(negedge clk);
            if ((which ? ready3 : ready0) === 1'b1) begin
                rd   = which ? rdata3 : rdata0;
                er   = which ? slverr3 : slverr0;
                done = 1'b1;
            end else if (cyc >= 40) begin
                check("xfer_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        sel0 = 1'b0; sel3 = 1'b0; enable = 1'b0;
    endtask

    task automatic run(input bit which, input string name, input bit w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_rdata, input bit exp_err, input int exp_cyc);
        exp_t        e;
        logic [31:0] rd;
        bit          er;
        int          cyc;
        sb_q.push_back('{name, exp_rdata, exp_err, exp_cyc});
        xfer(which, a, w, d, s, rd, er, cyc);
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, rd, e.rdata);
        check({e.name, "_slverr"}, {31'd0, er}, {31'd0, e.err});
        check({e.name, "_cycles"}, 32'(cyc), 32'(e.cyc));
    endtask

    initial begin
        int cyc;
        //          name        wr    addr       wdata          strb     rdata          err   cyc  wr     idx  reg
        vecs[0]  = '{"wr_full",   1'b1, 32'h0,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2, 8'h02, 1, 32'hDEADBEEF};
        vecs[0].addr = 32'h4;
        vecs[1]  = '{"rd_full",   1'b0, 32'h4,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, 8'h00, 1, 32'hDEADBEEF};
        vecs[2]  = '{"wr_byte0",  1'b1, 32'h4,  32'h000000AA, 4'h1, 32'h0,        1'b0, 2, 8'h02, 1, 32'hDEADBEAA};
        vecs[3]  = '{"rd_byte0",  1'b0, 32'h4,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 2, 8'h00, 1, 32'hDEADBEAA};
        vecs[4]  = '{"rd_reset",  1'b0, 32'h0,  32'h0,        4'h0, 32'h12345678, 1'b0, 2, 8'h00, 0, 32'h12345678};
        vecs[5]  = '{"wr_oob",    1'b1, 32'h20, 32'h00000055, 4'hF, 32'h0,        1'b1, 2, 8'h00, 1, 32'hDEADBEAA};
        vecs[6]  = '{"rd_misal",  1'b0, 32'h2,  32'h0,        4'h0, 32'h0,        1'b1, 2, 8'h00, 0, 32'h12345678};
        vecs[7]  = '{"rd_oob",    1'b0, 32'h20, 32'h0,        4'h0, 32'h0,        1'b1, 2, 8'h00, 1, 32'hDEADBEAA};
        vecs[8]  = '{"wr_ro",     1'b1, 32'h8,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 2, 8'h00, 2, 32'h0};
        vecs[9]  = '{"rd_ro",     1'b0, 32'h8,  32'h0,        4'h0, 32'hCAFE0001, 1'b0, 2, 8'h00, 2, 32'h0};
        vecs[10] = '{"wr_strb0",  1'b1, 32'hC,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 2, 8'h08, 3, 32'h0};
        vecs[11] = '{"wr_strb_a", 1'b1, 32'hC,  32'h11223344, 4'hA, 32'h0,        1'b0, 2, 8'h08, 3, 32'h11003300};
        vecs[12] = '{"rd_reg3",   1'b0, 32'hC,  32'h0,        4'h0, 32'h11003300, 1'b0, 2, 8'h00, 3, 32'h11003300};
        vecs[13] = '{"rd_upper",  1'b0, 32'h100,32'h0,        4'h0, 32'h0,        1'b1, 2, 8'h00, 0, 32'h12345678};
        vecs[14] = '{"wr_misal",  1'b1, 32'h5,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 2, 8'h00, 1, 32'hDEADBEAA};
        vecs[15] = '{"wr_reg7",   1'b1, 32'h1C, 32'hA5A5A5A5, 4'hC, 32'h0,        1'b0, 2, 8'h80, 7, 32'hA5A50000};

        csr_in = '0;
        for (int i = 0; i < REGS; i++) begin
            csr_in[i*32 +: 32] = 32'hBAD00000 | 32'(i);
        end
        csr_in[2*32 +: 32] = 32'hCAFE0001;

        rst = 1'b1; sel0 = 1'b0; sel3 = 1'b0; enable = 1'b0; write = 1'b0;
        addr = '0; wdata = '0; strb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_reg0",   csr_out0[31:0], 32'h12345678);
        check("rst_reg1",   csr_out0[63:32], 32'h0);
        check("rst_ready",  {31'd0, ready0}, 32'd0);
        check("rst_csr_wr", {24'd0, csr_wr0}, 32'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run(1'b0, vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_cyc);
            @(negedge clk);
            check({vecs[i].name, "_csr_wr"}, {24'd0, csr_wr0}, {24'd0, vecs[i].exp_wr});
            check({vecs[i].name, "_reg"}, csr_out0[vecs[i].chk_idx*32 +: 32], vecs[i].exp_reg);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("wr_pulse_len", {24'd0, csr_wr0}, 32'd0);
        @(posedge clk); #1;

        // WAIT=3: each read takes 5 clocks, including one issued right after ready.
        run(1'b1, "w3_rd0a", 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0, 5);
        run(1'b1, "w3_rd0b", 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0, 5);

        // Select dropped mid-ACCESS: nothing commits, next transfer is full length.
        addr = 32'h8; write = 1'b1; wdata = 32'h99; strb = 4'hF; sel3 = 1'b1; enable = 1'b0;
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 sel3 = 1'b0;
        @(negedge clk);
        check("seldrop_ready", {31'd0, ready3}, 32'd0);
        @(posedge clk); #1 enable = 1'b0;
        @(negedge clk);
        check("seldrop_csr_wr", {24'd0, csr_wr3}, 32'd0);
        check("seldrop_reg2", csr_out3[95:64], 32'h0);
        @(posedge clk); #1;
        run(1'b1, "w3_after_drop", 1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 5);

        // Reset during ACCESS: wait count restarts once reset releases.
        addr = 32'h4; write = 1'b1; wdata = 32'h77; strb = 4'hF; sel3 = 1'b1; enable = 1'b0;
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rstmid_dut0_reg1", csr_out0[63:32], 32'h0);
        check("rstmid_ready", {31'd0, ready3}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ready3 === 1'b1) break;
            @(posedge clk); #1;
        end
        check("rstmid_cycles", 32'(cyc), 32'd4);
        @(posedge clk); #1 sel3 = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("rstmid_csr_wr", {24'd0, csr_wr3}, 32'h02);
        check("rstmid_reg1", csr_out3[63:32], 32'h77);
        check("rstmid_dut0_reg0", csr_out0[31:0], 32'h12345678);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
